mem_bus_arbiter: RTL and testbench

- Two-master, one-slave memory bus arbiter between the RV32 core's instruction-fetch port (read-only) and its load/store port (read/write).
- Drives a single common memory bus that the processor wrapper converts into the SoC sel/ack interface.
- Grants one master per transaction and locks the grant until the slave signals completion.
- Routes ready/fault back only to the granted master.

---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/mem_bus_arbiter.sv | 113 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the two-master memory bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // GRANT_IDLE doubles as "no owner" when used for the effective owner.
  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory bus, locking the
// grant from the first cycle of a transaction until the slave completes it.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter logic DATA_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] instr_address_in,
  input  logic              instr_read_in,
  output logic [DATA_W-1:0] instr_read_value_out,
  output logic              instr_ready_out,
  output logic              instr_fault_out,
  input  logic [ADDR_W-1:0] data_address_in,
  input  logic              data_read_in,
  input  logic              data_write_in,
  output logic [DATA_W-1:0] data_read_value_out,
  input  logic [MASK_W-1:0] data_write_mask_in,
  input  logic [DATA_W-1:0] data_write_value_in,
  output logic              data_ready_out,
  output logic              data_fault_out,
  output logic [ADDR_W-1:0] address_out,
  output logic              read_out,
  output logic              write_out,
  input  logic [DATA_W-1:0] read_value_in,
  output logic [MASK_W-1:0] write_mask_out,
  output logic [DATA_W-1:0] write_value_out,
  input  logic              ready_in,
  input  logic              fault_in,
  output grant_t            grant_state_o
);

  // Handshake: a master's request (read/write) is its valid and must stay
  // asserted with stable address/mask/data until its own ready or fault;
  // ready_in/fault_in are single-cycle pulses that end the transaction.

  grant_t grant_q, grant_d;
  grant_t owner;
  logic   instr_req, data_req, done;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;
  assign done      = ready_in | fault_in;

  always_comb begin
    owner = grant_q;
    if (grant_q == GRANT_IDLE) begin
      if (DATA_PRIORITY) begin
        if (data_req)       owner = GRANT_DATA;
        else if (instr_req) owner = GRANT_INSTR;
        else                owner = GRANT_IDLE;
      end else begin
        if (instr_req)      owner = GRANT_INSTR;
        else if (data_req)  owner = GRANT_DATA;
        else                owner = GRANT_IDLE;
      end
    end
  end

  always_comb begin
    address_out     = '0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    instr_ready_out = 1'b0;
    instr_fault_out = 1'b0;
    data_ready_out  = 1'b0;
    data_fault_out  = 1'b0;
    case (owner)
      GRANT_INSTR: begin
        address_out     = instr_address_in;
        read_out        = instr_read_in;
        instr_ready_out = ready_in;
        instr_fault_out = fault_in;
      end
      GRANT_DATA: begin
        address_out     = data_address_in;
        read_out        = data_read_in;
        write_out       = data_write_in;
        write_mask_out  = data_write_mask_in;
        write_value_out = data_write_value_in;
        data_ready_out  = ready_in;
        data_fault_out  = fault_in;
      end
      default: ;
    endcase
  end

  assign instr_read_value_out = read_value_in;
  assign data_read_value_out  = read_value_in;

  // A response in the same cycle as the idle grant completes it without locking.
  always_comb begin
    grant_d = grant_q;
    if (ce_i) begin
      case (grant_q)
        GRANT_IDLE: if (owner != GRANT_IDLE && !done) grant_d = owner;
        default:    if (done) grant_d = GRANT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) grant_q <= GRANT_IDLE;
    else       grant_q <= grant_d;
  end

  assign grant_state_o = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives one arbiter per priority setting with shared stimulus and checks both
// against a per-cycle reference model plus directed literal expectations.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1, ce = 1'b1;
  logic [31:0] ia = '0, da = '0, dv = '0, rv = '0;
  logic        ir = 1'b0, dr = 1'b0, dw = 1'b0, rdy = 1'b0, flt = 1'b0;
  logic [3:0]  dm = '0;

  logic [31:0] irv0, drv0, addr0, wv0, irv1, drv1, addr1, wv1;
  logic        irdy0, iflt0, drdy0, dflt0, rd0, wr0;
  logic        irdy1, iflt1, drdy1, dflt1, rd1, wr1;
  logic [3:0]  wm0, wm1;
  grant_t      g0, g1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int st[2] = '{0, 0};  // model lock: 0 none, 1 instr, 2 data; index = DATA_PRIORITY

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_PRIORITY(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .ce_i(ce),
    .instr_address_in(ia), .instr_read_in(ir), .instr_read_value_out(irv0),
    .instr_ready_out(irdy0), .instr_fault_out(iflt0),
    .data_address_in(da), .data_read_in(dr), .data_write_in(dw),
    .data_read_value_out(drv0), .data_write_mask_in(dm), .data_write_value_in(dv),
    .data_ready_out(drdy0), .data_fault_out(dflt0),
    .address_out(addr0), .read_out(rd0), .write_out(wr0), .read_value_in(rv),
    .write_mask_out(wm0), .write_value_out(wv0), .ready_in(rdy), .fault_in(flt),
    .grant_state_o(g0)
  );

  mem_bus_arbiter #(.DATA_PRIORITY(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .ce_i(ce),
    .instr_address_in(ia), .instr_read_in(ir), .instr_read_value_out(irv1),
    .instr_ready_out(irdy1), .instr_fault_out(iflt1),
    .data_address_in(da), .data_read_in(dr), .data_write_in(dw),
    .data_read_value_out(drv1), .data_write_mask_in(dm), .data_write_value_in(dv),
    .data_ready_out(drdy1), .data_fault_out(dflt1),
    .address_out(addr1), .read_out(rd1), .write_out(wr1), .read_value_in(rv),
    .write_mask_out(wm1), .write_value_out(wv1), .ready_in(rdy), .fault_in(flt),
    .grant_state_o(g1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Who drives the bus this cycle, straight from the arbitration rules.
  function automatic int owner_of(int lock, bit dprio, bit ireq, bit dreq);
    if (lock != 0) return lock;
    if (dprio) return dreq ? 2 : (ireq ? 1 : 0);
    return ireq ? 1 : (dreq ? 2 : 0);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int own;
      own = owner_of(st[k], k[0], ir, dr | dw);
      if (reset) st[k] <= 0;
      else if (ce) begin
        if (st[k] == 0 && own != 0 && !(rdy | flt)) st[k] <= own;
        else if (st[k] != 0 && (rdy | flt)) st[k] <= 0;
      end
    end
  end

  task automatic check_inst(input int k, input grant_t g, input logic [31:0] addr,
                            input logic rd, input logic wr, input logic [3:0] wm,
                            input logic [31:0] wv, input logic irdy, input logic iflt,
                            input logic drdy, input logic dflt,
                            input logic [31:0] irv, input logic [31:0] drv);
    int own;
    logic [31:0] e_addr, e_wv;
    logic        e_rd, e_wr;
    logic [3:0]  e_wm;
    own = owner_of(st[k], k[0], ir, dr | dw);
    e_addr = (own == 2) ? da : (own == 1) ? ia : 32'h0;
    e_rd   = (own == 2) ? dr : (own == 1) ? ir : 1'b0;
    e_wr   = (own == 2) ? dw : 1'b0;
    e_wm   = (own == 2) ? dm : 4'h0;
    e_wv   = (own == 2) ? dv : 32'h0;
    check($sformatf("m%0d_state", k), 32'(g), 32'(st[k]));
    check($sformatf("m%0d_addr", k), addr, e_addr);
    check($sformatf("m%0d_rd", k), 32'(rd), 32'(e_rd));
    check($sformatf("m%0d_wr", k), 32'(wr), 32'(e_wr));
    check($sformatf("m%0d_mask", k), 32'(wm), 32'(e_wm));
    check($sformatf("m%0d_wval", k), wv, e_wv);
    check($sformatf("m%0d_irdy", k), 32'(irdy), 32'(rdy & (own == 1)));
    check($sformatf("m%0d_iflt", k), 32'(iflt), 32'(flt & (own == 1)));
    check($sformatf("m%0d_drdy", k), 32'(drdy), 32'(rdy & (own == 2)));
    check($sformatf("m%0d_dflt", k), 32'(dflt), 32'(flt & (own == 2)));
    check($sformatf("m%0d_irv", k), irv, rv);
    check($sformatf("m%0d_drv", k), drv, rv);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, g0, addr0, rd0, wr0, wm0, wv0, irdy0, iflt0, drdy0, dflt0, irv0, drv0);
      check_inst(1, g1, addr1, rd1, wr1, wm1, wv1, irdy1, iflt1, drdy1, dflt1, irv1, drv1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ir = 1'b1; dw = 1'b1; rv = 32'hA5A5_0001;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_state1", 32'(g1), 32'(GRANT_IDLE));
    check("rst_state0", 32'(g0), 32'(GRANT_IDLE));
    reset = 1'b0; ia = 32'hF000_0000; dw = 1'b0; rdy = 1'b0;
    cyc();
    @(negedge clk);
    check("lock_state", 32'(g1), 32'(GRANT_INSTR));
    check("lock_addr", addr1, 32'hF000_0000);
    check("lock_rd", 32'(rd1), 32'd1);
    check("lock_wr", 32'(wr1), 32'd0);
    dr = 1'b1; da = 32'h0000_2000;
    @(negedge clk);
    check("lock_hold_addr", addr1, 32'hF000_0000);
    check("lock_hold_drdy", 32'(drdy1), 32'd0);
    cyc(); rdy = 1'b1;
    @(negedge clk);
    check("lock_irdy", 32'(irdy1), 32'd1);
    check("lock_drdy", 32'(drdy1), 32'd0);
    cyc(); rdy = 1'b0; ir = 1'b0;
    @(negedge clk);
    check("handoff_addr", addr1, 32'h0000_2000);
    cyc(); rdy = 1'b1;
    @(negedge clk);
    check("handoff_drdy", 32'(drdy1), 32'd1);
    cyc(); rdy = 1'b0; dr = 1'b0;

    ir = 1'b1; ia = 32'h0000_3000;
    dw = 1'b1; da = 32'h0000_1000; dv = 32'hDEAD_BEEF; dm = 4'hF;
    @(negedge clk);
    check("prio1_wr", 32'(wr1), 32'd1);
    check("prio1_addr", addr1, 32'h0000_1000);
    check("prio1_wval", wv1, 32'hDEAD_BEEF);
    check("prio0_addr", addr0, 32'h0000_3000);
    check("prio0_wr", 32'(wr0), 32'd0);
    cyc(); rdy = 1'b1;
    @(negedge clk);
    check("prio1_drdy", 32'(drdy1), 32'd1);
    check("prio1_irdy", 32'(irdy1), 32'd0);
    check("prio0_irdy", 32'(irdy0), 32'd1);
    check("prio0_drdy", 32'(drdy0), 32'd0);
    cyc(); rdy = 1'b0; dw = 1'b0;
    @(negedge clk);
    check("prio1_next_addr", addr1, 32'h0000_3000);
    check("prio1_next_rd", 32'(rd1), 32'd1);
    cyc(); rdy = 1'b1;
    cyc(); rdy = 1'b0; ir = 1'b0;

    dr = 1'b1; da = 32'h0000_4000;
    cyc(); flt = 1'b1;
    @(negedge clk);
    check("fault_dflt", 32'(dflt1), 32'd1);
    check("fault_iflt", 32'(iflt1), 32'd0);
    cyc(); flt = 1'b0; dr = 1'b0;
    @(negedge clk);
    check("fault_state", 32'(g1), 32'(GRANT_IDLE));

    dr = 1'b1; da = 32'h0000_5000;
    cyc(); ce = 1'b0; rdy = 1'b1;
    cyc(); ce = 1'b1; rdy = 1'b0;
    @(negedge clk);
    check("ce_hold_state", 32'(g1), 32'(GRANT_DATA));
    rdy = 1'b1;
    cyc(); rdy = 1'b0; dr = 1'b0;
    @(negedge clk);
    check("ce_release_state", 32'(g1), 32'(GRANT_IDLE));

    check("idle_addr", addr1, 32'h0);
    check("idle_rd", 32'(rd1), 32'd0);
    check("idle_wr", 32'(wr1), 32'd0);
    check("idle_mask", 32'(wm1), 32'd0);
    check("idle_wval", wv1, 32'h0);
    dr = 1'b1; da = 32'h0000_6000; rdy = 1'b1;
    @(negedge clk);
    check("single_drdy", 32'(drdy1), 32'd1);
    cyc(); dr = 1'b0; rdy = 1'b0;
    @(negedge clk);
    check("single_state", 32'(g1), 32'(GRANT_IDLE));

    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      ce    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) ir = ~ir;
      if ($urandom_range(0, 3) == 0) dr = ~dr;
      if ($urandom_range(0, 4) == 0) dw = ~dw;
      if ($urandom_range(0, 3) == 0) ia = $urandom;
      if ($urandom_range(0, 3) == 0) da = $urandom;
      dv  = $urandom;
      dm  = 4'($urandom_range(0, 15));
      rv  = $urandom;
      rdy = ($urandom_range(0, 2) == 0);
      flt = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
